serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//   Multi-cycle, parametrised adder built from a CHUNK-bit full-adder chain.
//   It adds two WIDTH-bit operands, CHUNK bits per clock, starting at the LSB.
//   A start/busy/done handshake controls each operation.
//   It is the sequential successor of the single-bit full adder. It is used
//   wherever wide additions must trade latency for area.
// PARAMETERS
//   WIDTH  8  operand/sum width in bits; must be >= 2
//   CHUNK  1  bits added per cycle; must be >= 1; WIDTH % CHUNK must be 0
//   (derived) NCHUNK = WIDTH/CHUNK, the number of RUN cycles per operation
// PORTS
//   clk    in   1      single clock; all logic updates on its rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only while in IDLE
//   A      in   WIDTH  operand A; captured on the accepting edge
//   B      in   WIDTH  operand B; captured on the accepting edge
//   C_in   in   1      carry-in; captured on the accepting edge
//   S      out  WIDTH  sum (registered)
//   C_out  out  1      carry-out of bit WIDTH-1 (registered)
//   ovf    out  1      signed overflow: carry into MSB XOR C_out (registered)
//   busy   out  1      high in RUN and in DONE
//   done   out  1      one-cycle pulse; S/C_out/ovf are valid from it onward
// BEHAVIOUR
//   Reset (rst=1 at an edge): state=IDLE, count=0. S=0, C_out=0, ovf=0,
//     busy=0, done=0. Operand registers are cleared. rst overrides every
//     other input, including mid-RUN; the partial result is discarded.
//   States: IDLE, RUN, DONE (binary encoded; busy/done decoded from state).
//   IDLE: with start=1, latch A, B and C_in into shift registers, then
//     count<=0 and go to RUN. With start=0, remain in IDLE.
//   RUN: each edge adds the low CHUNK bits of opA and opB plus the carry
//     register through a ripple chain. The sum chunk shifts into the partial
//     sum register from the MSB end. opA and opB shift right by CHUNK. The
//     carry register takes the chain carry-out. count increments.
//     On the edge where count==NCHUNK-1: load S from the assembled sum, set
//     C_out from the final carry and ovf from carry-into-MSB XOR final carry,
//     then go to DONE.
//   DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
//   Latency: if start is accepted at edge k, done is high in the cycle after
//     edge k+NCHUNK. Minimum start-to-start interval is NCHUNK+2 cycles.
//   start in RUN or DONE is ignored, not queued.
//   A, B and C_in may change freely after the accepting edge.
//   S, C_out and ovf hold their values between completions. They change only
//     on the edge entering DONE, or on reset.
//   Arithmetic is modulo 2^WIDTH. The carry beyond the MSB appears only on
//     C_out.
//   Wrap-around example: all-ones + 1 gives S=0, C_out=1.
//   Corner case: with CHUNK==WIDTH, NCHUNK=1, so RUN lasts exactly one cycle.
// CONFIGURATION
//   SERIAL_ADDER_SUB_EN defined: adds input port sub (1 bit), captured with
//     the operands. When sub=1, the block captures ~B and forces the captured
//     carry to 1, ignoring C_in. The result is S = A - B (mod 2^WIDTH).
//     C_out=1 means no borrow. ovf flags signed overflow of the subtraction.
//   SERIAL_ADDER_SUB_EN undefined: port sub does not exist. The block is a
//     pure adder, and C_in is always used.
// TESTING
//   1. Reset: W8/C1, assert rst 2 cycles -> S=0, C_out=0, ovf=0, busy=0,
//      done=0.
//   2. W8/C1: A=8'h3C, B=8'h05, C_in=1, start pulse -> done exactly 8 cycles
//      after the accepting edge; S=8'h42, C_out=0, ovf=0; busy high for 9
//      cycles.
//   3. Wrap/overflow, W8/C2: A=8'hFF, B=8'h01, C_in=0 -> S=8'h00, C_out=1,
//      ovf=0. Then A=8'h7F, B=8'h01 -> S=8'h80, C_out=0, ovf=1. Each done
//      arrives after 4 cycles.
//   4. Handshake: hold start=1 continuously with changing A/B -> one
//      operation per NCHUNK+2 cycles. Operands are taken only on IDLE edges,
//      and results match the captured values.
//   5. Reset mid-op: rst at RUN cycle 3 -> IDLE next cycle, no done pulse,
//      S=0. A subsequent op (8'h10+8'h20) gives S=8'h30.
//   6. With SERIAL_ADDER_SUB_EN, W8/C4: sub=1, A=8'h05, B=8'h07 -> S=8'hFE,
//      C_out=0, ovf=0. Then sub=1, A=8'h80, B=8'h01 -> S=8'h7F, C_out=1,
//      ovf=1.

Source files
------------

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_if
//  Description : Operand/result bundle for serial_adder.
//                master = requester (drives start, A, B, C_in[, sub]),
//                slave  = serial_adder (drives S, C_out, ovf, busy, done).
//  Signals     : start  request, sampled only while the adder is idle
//                A, B   WIDTH-bit operands, C_in carry-in
//                sub    subtract select (only with SERIAL_ADDER_SUB_EN)
//                S      WIDTH-bit sum, C_out carry-out, ovf signed overflow
//                busy   operation in progress, done one-cycle completion pulse
//  Config      : SERIAL_ADDER_SUB_EN adds the sub signal.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             ovf;
    logic             busy;
    logic             done;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (
        output start, A, B, C_in, sub,
        input  S, C_out, ovf, busy, done
    );
    modport slave (
        input  start, A, B, C_in, sub,
        output S, C_out, ovf, busy, done
    );
`else
    modport master (
        output start, A, B, C_in,
        input  S, C_out, ovf, busy, done
    );
    modport slave (
        input  start, A, B, C_in,
        output S, C_out, ovf, busy, done
    );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Multi-cycle WIDTH-bit adder. Each RUN cycle pushes CHUNK bits
//                of both operands (LSB first) through a CHUNK-bit ripple
//                full-adder chain; the carry is held in a register between
//                cycles. One operation takes NCHUNK = WIDTH/CHUNK RUN cycles
//                followed by a single DONE cycle.
//  Parameters  : WIDTH  operand/sum width (>= 2)
//                CHUNK  bits added per cycle (>= 1, divides WIDTH)
//  Ports       : clk    rising-edge clock
//                rst    synchronous active-high reset
//                bus    serial_adder_if.slave (start/A/B/C_in[/sub] in,
//                       S/C_out/ovf/busy/done out)
//  Config      : SERIAL_ADDER_SUB_EN -- when defined, bus.sub=1 turns the
//                operation into A - B (B inverted, carry-in forced to 1).
//  Revision    : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int c_nchunk = WIDTH / CHUNK;
    localparam int c_cnt_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nchunk - 1);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic               r_carry;
    logic [WIDTH-1:0]   r_s;
    logic               r_c_out;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_b_capt;
    logic               w_cin_capt;
    logic [CHUNK:0]     w_carry;
    logic [CHUNK-1:0]   w_sum_chunk;
    logic [WIDTH-1:0]   w_psum_next;

    // Operand conditioning at capture time: subtraction is A + ~B + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_capt   = bus.sub ? ~bus.B : bus.B;
    assign w_cin_capt = bus.sub | bus.C_in;
`else
    assign w_b_capt   = bus.B;
    assign w_cin_capt = bus.C_in;
`endif

    // CHUNK-bit ripple chain fed by the low bits of the shifting operands.
    assign w_carry[0] = r_carry;
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign w_sum_chunk[i] = r_op_a[i] ^ r_op_b[i] ^ w_carry[i];
        assign w_carry[i+1]   = (r_op_a[i] & r_op_b[i]) |
                                (w_carry[i] & (r_op_a[i] ^ r_op_b[i]));
    end

    // Partial sum: each new chunk enters at the MSB end, so after the last
    // RUN cycle the first chunk has drifted down to bit 0. Only the upper
    // WIDTH-CHUNK bits ever need storing; the final chunk is taken straight
    // from the chain when S is loaded.
    if (CHUNK < WIDTH) begin : g_psum_shift
        logic [WIDTH-CHUNK-1:0] r_psum;

        assign w_psum_next = {w_sum_chunk, r_psum};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_psum <= '0;
            end else if (r_state == c_run) begin
                r_psum <= w_psum_next[WIDTH-1:CHUNK];
            end
        end
    end else begin : g_psum_whole
        assign w_psum_next = w_sum_chunk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_count <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_carry <= 1'b0;
            r_s     <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        r_op_a  <= bus.A;
                        r_op_b  <= w_b_capt;
                        r_carry <= w_cin_capt;
                        r_count <= '0;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    r_op_a  <= r_op_a >> CHUNK;
                    r_op_b  <= r_op_b >> CHUNK;
                    r_carry <= w_carry[CHUNK];
                    r_count <= r_count + c_cnt_w'(1);
                    if (r_count == c_last) begin
                        // The chain is processing the top chunk here, so
                        // w_carry[CHUNK-1] is the carry into the MSB.
                        r_s     <= w_psum_next;
                        r_c_out <= w_carry[CHUNK];
                        r_ovf   <= w_carry[CHUNK-1] ^ w_carry[CHUNK];
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.S     = r_s;
    assign bus.C_out = r_c_out;
    assign bus.ovf   = r_ovf;
    assign bus.busy  = (r_state != c_idle);
    assign bus.done  = (r_state == c_done);

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. Four instances with
//                WIDTH=8 and CHUNK=1,2,4,8. Expected results are queued when
//                an operation is issued; a monitor pops and compares them on
//                every done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    typedef struct {
        int         d;
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] a_drv;
    logic [7:0] b_drv;
    logic       cin_drv;
    logic       sub_drv;
    logic [3:0] start_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] cout_v;
    logic [3:0] ovf_v;
    logic [7:0] s_v [4];

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Instance g has CHUNK = 1 << g, i.e. NCHUNK = 8 >> g.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_adder_if #(.WIDTH(8)) bus ();

        serial_adder #(.WIDTH(8), .CHUNK(1 << g)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.start = start_v[g];
        assign bus.A     = a_drv;
        assign bus.B     = b_drv;
        assign bus.C_in  = cin_drv;
`ifdef SERIAL_ADDER_SUB_EN
        assign bus.sub   = sub_drv;
`endif
        assign s_v[g]    = bus.S;
        assign cout_v[g] = bus.C_out;
        assign ovf_v[g]  = bus.ovf;
        assign busy_v[g] = bus.busy;
        assign done_v[g] = bus.done;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] s, input logic c, input logic v);
        exp_t e;
        e.d = d;
        e.s = s;
        e.c = c;
        e.v = v;
        q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (done_v[d] === 1'b1) begin
                if (q.size() == 0) begin
                    chk($sformatf("spurious_done_d%0d", d), 32'(done_v[d]), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk($sformatf("done_source_d%0d", d), d, e.d);
                    chk($sformatf("S_d%0d", d), 32'(s_v[d]), 32'(e.s));
                    chk($sformatf("C_out_d%0d", d), 32'(cout_v[d]), 32'(e.c));
                    chk($sformatf("ovf_d%0d", d), 32'(ovf_v[d]), 32'(e.v));
                end
            end
        end
    end

    // One operation on instance d, issued at a negedge. Checks done timing
    // and busy duration; result values are checked by the monitor. Inputs
    // are scrambled after the accepting edge to show they are not re-read.
    task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic sub,
                          input logic [7:0] es, input logic ec, input logic ev);
        int nch;
        int done_at;
        int done_n;
        int busy_n;
        nch     = 8 >> d;
        done_at = -1;
        done_n  = 0;
        busy_n  = 0;
        a_drv   = a;
        b_drv   = b;
        cin_drv = cin;
        sub_drv = sub;
        start_v[d] = 1'b1;
        push(d, es, ec, ev);
        for (int m = 0; m <= nch + 3; m++) begin
            @(negedge clk);
            if (m == 0) begin
                start_v[d] = 1'b0;
                a_drv   = ~a;
                b_drv   = 8'h5A;
                cin_drv = ~cin;
                sub_drv = ~sub;
            end
            if (busy_v[d] === 1'b1) busy_n++;
            if (done_v[d] === 1'b1) begin
                done_n++;
                if (done_at < 0) done_at = m;
            end
        end
        chk($sformatf("done_latency_d%0d", d), done_at, nch);
        chk($sformatf("done_pulses_d%0d", d), done_n, 1);
        chk($sformatf("busy_cycles_d%0d", d), busy_n, nch + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n;
        rst     = 1'b1;
        start_v = 4'b0;
        a_drv   = 8'h00;
        b_drv   = 8'h00;
        cin_drv = 1'b0;
        sub_drv = 1'b0;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset_S_d%0d", d), 32'(s_v[d]), 32'd0);
            chk($sformatf("reset_C_out_d%0d", d), 32'(cout_v[d]), 32'd0);
            chk($sformatf("reset_ovf_d%0d", d), 32'(ovf_v[d]), 32'd0);
            chk($sformatf("reset_busy_d%0d", d), 32'(busy_v[d]), 32'd0);
            chk($sformatf("reset_done_d%0d", d), 32'(done_v[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Basic add, one bit per cycle: 3C + 05 + 1 = 42.
        run_op(0, 8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);

        // Two bits per cycle: wrap-around, then signed overflow.
        run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Whole word in one RUN cycle: FF + 01 + 1 = 1_01.
        run_op(3, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);

        // start held high with operands changing every cycle: accepts occur
        // at m = 0, 10, 20 only (A = 7m+3, B = 5m+1).
        done_n = 0;
        for (int m = 0; m < 30; m++) begin
            a_drv      = 8'(m * 7 + 3);
            b_drv      = 8'(m * 5 + 1);
            cin_drv    = 1'b0;
            sub_drv    = 1'b0;
            start_v[0] = 1'b1;
            if (m == 0)  push(0, 8'h04, 1'b0, 1'b0);
            if (m == 10) push(0, 8'h7C, 1'b0, 1'b0);
            if (m == 20) push(0, 8'hF4, 1'b0, 1'b0);
            @(negedge clk);
            if (done_v[0] === 1'b1) begin
                done_n++;
                chk("held_start_done_slot", m % 10, 8);
            end
        end
        start_v[0] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) done_n++;
        end
        chk("held_start_done_count", done_n, 3);

        // Reset in the middle of a RUN: no result, S cleared.
        a_drv      = 8'h55;
        b_drv      = 8'h11;
        cin_drv    = 1'b0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_reset_busy", 32'(busy_v[0]), 32'd0);
        chk("midrun_reset_S", 32'(s_v[0]), 32'd0);
        done_n = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) done_n++;
        end
        chk("midrun_reset_no_done", done_n, 0);
        run_op(0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

        // Four bits per cycle.
`ifdef SERIAL_ADDER_SUB_EN
        // C_in is ignored while subtracting.
        run_op(2, 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op(2, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
`else
        run_op(2, 8'h05, 8'h07, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0);
        run_op(2, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("results_outstanding", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
